// File: rtl/alu_sequencer.sv
// alu_sequencer: buffers ALU commands in a FIFO, drives one operation at a time onto
// registered ALU inputs, waits a settle time, then returns the captured result.
module alu_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_select,
    input  logic [7:0] cmd_num1,
    input  logic [7:0] cmd_num2,
    input  logic       cmd_use_acc,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [3:0] alu_select,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic [7:0] acc,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] num1;
        logic [7:0] num2;
        logic       useAcc;
    } cmd_t;

    cmd_t            fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]     count_q, count_d;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      aluNum1_q, aluNum1_d;
    logic [7:0]      aluNum2_q, aluNum2_d;
    logic [3:0]      aluSelect_q, aluSelect_d;
    logic [7:0]      rspResult_q, rspResult_d;
    logic            rspZero_q, rspZero_d;
    logic            rspValid_q, rspValid_d;
    logic [7:0]      acc_q, acc_d;

    logic            fifoEmpty;
    logic            fifoFull;
    logic            push;
    logic            pop;
    cmd_t            head;
    cmd_t            incoming;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == (AW+1)'(FIFO_DEPTH));
    // Ready depends only on registered occupancy; reset forces it low while asserted.
    assign cmd_ready = !fifoFull && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && !fifoEmpty;
    assign head      = fifoMem_q[rdPtr_q];
    assign incoming  = '{sel: cmd_select, num1: cmd_num1, num2: cmd_num2, useAcc: cmd_use_acc};

    assign alu_num1   = aluNum1_q;
    assign alu_num2   = aluNum2_q;
    assign alu_select = aluSelect_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = rspResult_q;
    assign rsp_zero   = rspZero_q;
    assign acc        = acc_q;
    assign busy       = (state_q != IDLE) || !fifoEmpty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= incoming;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            aluNum1_q   <= '0;
            aluNum2_q   <= '0;
            aluSelect_q <= '0;
            rspResult_q <= '0;
            rspZero_q   <= 1'b0;
            rspValid_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aluNum1_q   <= aluNum1_d;
            aluNum2_q   <= aluNum2_d;
            aluSelect_q <= aluSelect_d;
            rspResult_q <= rspResult_d;
            rspZero_q   <= rspZero_d;
            rspValid_q  <= rspValid_d;
            acc_q       <= acc_d;
        end
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        aluNum1_d   = aluNum1_q;
        aluNum2_d   = aluNum2_q;
        aluSelect_d = aluSelect_q;
        rspResult_d = rspResult_q;
        rspZero_d   = rspZero_q;
        rspValid_d  = rspValid_q;
        acc_d       = acc_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    aluSelect_d = head.sel;
                    aluNum2_d   = head.num2;
                    // Accumulator is already updated here, so chained ops see the previous result.
                    aluNum1_d   = head.useAcc ? acc_q : head.num1;
                    cnt_d       = CW'(SETTLE_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    rspResult_d = alu_result;
                    acc_d       = alu_result;
                    rspZero_d   = (alu_result == 8'd0);
                    rspValid_d  = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural ALU and checks every
// response through a scoreboard plus directed latency, backpressure and reset checks.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_select;
    logic [7:0] cmd_num1;
    logic [7:0] cmd_num2;
    logic       cmd_use_acc;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [3:0] alu_select;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic [7:0] acc;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;
    int handshakeCount = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } exp_t;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic [7:0] n1;
    } obs_t;

    exp_t sbQueue[$];
    obs_t obsLog[$];
    logic [7:0] modelAcc = 8'd0;

    alu_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_select(cmd_select),
        .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_use_acc(cmd_use_acc),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_select(alu_select),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .acc(acc), .busy(busy)
    );

    // Stand-in for the team's combinational 8-bit ALU
    function automatic logic [7:0] aluModel(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            4'd0:    aluModel = a + b;
            4'd1:    aluModel = a - b;
            4'd2:    aluModel = a & b;
            4'd3:    aluModel = a | b;
            4'd4:    aluModel = a ^ b;
            4'd5:    aluModel = a << 1;
            4'd6:    aluModel = a >> 1;
            default: aluModel = a;
        endcase
    endfunction

    assign alu_result = aluModel(alu_select, alu_num1, alu_num2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Handshakes are sampled mid-cycle, where inputs and outputs are both settled
    always @(negedge clk) begin
        if (reset) begin
            sbQueue.delete();
            modelAcc = 8'd0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                e.sel = cmd_select;
                e.a   = cmd_use_acc ? modelAcc : cmd_num1;
                e.b   = cmd_num2;
                e.res = aluModel(e.sel, e.a, e.b);
                modelAcc = e.res;
                sbQueue.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
                obs_t o;
                handshakeCount++;
                o.res = rsp_result;
                o.zero = rsp_zero;
                o.n1 = alu_num1;
                obsLog.push_back(o);
                if (sbQueue.size() == 0) begin
                    checkOutput("sbOrphanResponse", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbQueue.pop_front();
                    checkOutput("sbResult", 32'(rsp_result), 32'(e.res));
                    checkOutput("sbZero", 32'(rsp_zero), 32'(e.res == 8'd0));
                    checkOutput("sbAcc", 32'(acc), 32'(e.res));
                    checkOutput("sbAluNum1", 32'(alu_num1), 32'(e.a));
                    checkOutput("sbAluNum2", 32'(alu_num2), 32'(e.b));
                    checkOutput("sbAluSelect", 32'(alu_select), 32'(e.sel));
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] n1, input logic [7:0] n2, input logic useAcc);
        int guard;
        cmd_select  = sel;
        cmd_num1    = n1;
        cmd_num2    = n2;
        cmd_use_acc = useAcc;
        cmd_valid   = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            stepCycle();
            guard++;
        end
        if (!cmd_ready) checkOutput("cmdAcceptTimeout", 32'd0, 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int guard;
        guard = 0;
        while ((busy || rsp_valid) && guard < 200) begin
            stepCycle();
            guard++;
        end
        checkOutput(tag, 32'(busy || rsp_valid), 32'd0);
    endtask

    task automatic waitRsp(input string tag);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 200) begin
            stepCycle();
            guard++;
        end
        checkOutput(tag, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] snapResult;
        logic       snapZero;
        logic [7:0] snapN1;
        logic [7:0] snapN2;
        logic [3:0] snapSel;
        logic       stable;
        logic       sawRsp;
        int         hsBefore;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_select = '0;
        cmd_num1 = '0;
        cmd_num2 = '0;
        cmd_use_acc = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) stepCycle();
        checkOutput("resetCmdReady", 32'(cmd_ready), 32'd0);
        checkOutput("resetAluNum1", 32'(alu_num1), 32'd0);
        checkOutput("resetAluNum2", 32'(alu_num2), 32'd0);
        checkOutput("resetAluSelect", 32'(alu_select), 32'd0);
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetRspResult", 32'(rsp_result), 32'd0);
        checkOutput("resetRspZero", 32'(rsp_zero), 32'd0);
        checkOutput("resetAcc", 32'(acc), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("releaseCmdReady", 32'(cmd_ready), 32'd1);

        // Single add with exact latency
        $display("[TB] single add");
        cmd_select = 4'd0; cmd_num1 = 8'd5; cmd_num2 = 8'd3; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        stepCycle();
        cmd_valid = 1'b0;
        checkOutput("addT1RspValid", 32'(rsp_valid), 32'd0);
        checkOutput("addT1Busy", 32'(busy), 32'd1);
        stepCycle();
        checkOutput("addT2AluNum1", 32'(alu_num1), 32'd5);
        checkOutput("addT2AluNum2", 32'(alu_num2), 32'd3);
        checkOutput("addT2AluSelect", 32'(alu_select), 32'd0);
        checkOutput("addT2RspValid", 32'(rsp_valid), 32'd0);
        stepCycle();
        checkOutput("addT3RspValid", 32'(rsp_valid), 32'd1);
        checkOutput("addT3RspResult", 32'(rsp_result), 32'd8);
        checkOutput("addT3RspZero", 32'(rsp_zero), 32'd0);
        checkOutput("addT3Acc", 32'(acc), 32'd8);
        stepCycle();
        checkOutput("addT4RspValid", 32'(rsp_valid), 32'd0);
        waitIdle("addIdle");

        // Accumulator chaining
        $display("[TB] chaining");
        obsLog.delete();
        applyStimulus(4'd0, 8'h10, 8'h20, 1'b0);
        applyStimulus(4'd1, 8'hAA, 8'h30, 1'b1);
        waitIdle("chainIdle");
        checkOutput("chainCount", 32'(obsLog.size()), 32'd2);
        if (obsLog.size() == 2) begin
            checkOutput("chainRes0", 32'(obsLog[0].res), 32'h30);
            checkOutput("chainZero0", 32'(obsLog[0].zero), 32'd0);
            checkOutput("chainRes1", 32'(obsLog[1].res), 32'h00);
            checkOutput("chainZero1", 32'(obsLog[1].zero), 32'd1);
            checkOutput("chainNum1", 32'(obsLog[1].n1), 32'h30);
        end

        // FIFO full: one in flight plus four buffered, sixth rejected until a pop
        $display("[TB] fifo full");
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_select = 4'(i % 5);
            cmd_num1 = 8'(8'h11 * (i + 1));
            cmd_num2 = 8'(8'h07 + i);
            cmd_use_acc = (i == 3);
            cmd_valid = 1'b1;
            checkOutput($sformatf("fullReady%0d", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
            stepCycle();
        end
        checkOutput("fullStillBlocked", 32'(cmd_ready), 32'd0);
        checkOutput("fullRspValid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        checkOutput("fullAfterHsReady", 32'(cmd_ready), 32'd0);
        stepCycle();
        checkOutput("fullAfterPopReady", 32'(cmd_ready), 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        waitIdle("fullDrainIdle");

        // Backpressure
        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(4'd2, 8'h5A, 8'h0F, 1'b0);
        waitRsp("bpRspArrives");
        snapResult = rsp_result; snapZero = rsp_zero;
        snapN1 = alu_num1; snapN2 = alu_num2; snapSel = alu_select;
        checkOutput("bpResult", 32'(snapResult), 32'h0A);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (!(rsp_valid === 1'b1 && rsp_result === snapResult && rsp_zero === snapZero &&
                  alu_num1 === snapN1 && alu_num2 === snapN2 && alu_select === snapSel))
                stable = 1'b0;
        end
        checkOutput("bpStable", 32'(stable), 32'd1);
        hsBefore = handshakeCount;
        rsp_ready = 1'b1;
        repeat (3) stepCycle();
        checkOutput("bpOneHandshake", 32'(handshakeCount - hsBefore), 32'd1);
        waitIdle("bpIdle");

        // Reset while an op is in WAIT with two commands queued
        $display("[TB] reset mid-wait");
        rsp_ready = 1'b0;
        applyStimulus(4'd0, 8'h01, 8'h02, 1'b0);
        applyStimulus(4'd0, 8'h03, 8'h04, 1'b0);
        applyStimulus(4'd0, 8'h05, 8'h06, 1'b0);
        applyStimulus(4'd0, 8'h07, 8'h08, 1'b0);
        waitRsp("rstFirstRsp");
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        stepCycle();
        checkOutput("rstPreBusy", 32'(busy), 32'd1);
        checkOutput("rstPreRspValid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        #1;
        checkOutput("rstPostRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstPostBusy", 32'(busy), 32'd0);
        checkOutput("rstPostAcc", 32'(acc), 32'd0);
        checkOutput("rstPostCmdReady", 32'(cmd_ready), 32'd1);
        hsBefore = handshakeCount;
        rsp_ready = 1'b1;
        sawRsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        checkOutput("rstNoRsp", 32'(sawRsp), 32'd0);
        checkOutput("rstNoHandshake", 32'(handshakeCount - hsBefore), 32'd0);

        // Accumulator restarts from zero after reset
        obsLog.delete();
        applyStimulus(4'd0, 8'hEE, 8'h07, 1'b1);
        waitIdle("postRstIdle");
        checkOutput("postRstCount", 32'(obsLog.size()), 32'd1);
        if (obsLog.size() == 1) checkOutput("postRstAccChain", 32'(obsLog[0].res), 32'h07);

        checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
